tx_response_scheduler: RTL

TX_RESPONSE_SCHEDULER -- requirements
Module: tx_response_scheduler

---
 rtl/tx_response_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/tx_response_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tx_response_scheduler
// Brief   : Round-robin scheduler forwarding RF (1 byte) and ALU (2 byte)
//           results to a UART transmitter with busy handshake and retry.
// Revision: 1.0 - initial release
// ============================================================================
module tx_response_scheduler #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        TXSch_CLK,
  input  logic        TXSch_RST,
  input  logic [7:0]  TXSch_RF_RdData,
  input  logic        TXSch_RF_RdValid,
  input  logic [15:0] TXSch_ALU_Out,
  input  logic        TXSch_ALU_Valid,
  input  logic        TXSch_TX_Busy,
  output logic [7:0]  TXSch_TX_Pdata,
  output logic        TXSch_TX_Data_Valid,
  output logic        TXSch_Overrun,
  output logic        TXSch_Busy
);

  localparam logic [7:0] TMO_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  rf_data_q, rf_data_d;
  logic        rf_pend_q, rf_pend_d;
  logic [15:0] alu_data_q, alu_data_d;
  logic        alu_pend_q, alu_pend_d;
  logic        last_grant_q, last_grant_d;   // 1: ALU was granted last
  logic [15:0] txbuf_q, txbuf_d;
  logic [1:0]  bytes_q, bytes_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [7:0]  pdata_q, pdata_d;
  logic        dv_q, dv_d;
  logic        ovr_q, ovr_d;

  logic        grant_rf, grant_alu;
  logic        ovr_rf, ovr_alu;

  always_comb begin
    state_d      = state_q;
    rf_data_d    = rf_data_q;
    rf_pend_d    = rf_pend_q;
    alu_data_d   = alu_data_q;
    alu_pend_d   = alu_pend_q;
    last_grant_d = last_grant_q;
    txbuf_d      = txbuf_q;
    bytes_d      = bytes_q;
    tcnt_d       = tcnt_q;
    pdata_d      = pdata_q;
    dv_d         = 1'b0;
    ovr_d        = 1'b0;
    grant_rf     = 1'b0;
    grant_alu    = 1'b0;
    ovr_rf       = 1'b0;
    ovr_alu      = 1'b0;

    case (state_q)
      IDLE: begin
        if (rf_pend_q && (!alu_pend_q || last_grant_q)) begin
          grant_rf     = 1'b1;
          txbuf_d      = {8'h00, rf_data_q};
          bytes_d      = 2'd1;
          last_grant_d = 1'b0;
          state_d      = ISSUE;
        end else if (alu_pend_q) begin
          grant_alu    = 1'b1;
          txbuf_d      = alu_data_q;
          bytes_d      = 2'd2;
          last_grant_d = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (!TXSch_TX_Busy) begin
          pdata_d = txbuf_q[7:0];
          dv_d    = 1'b1;
          tcnt_d  = 8'd0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (TXSch_TX_Busy) begin
          state_d = WAIT_DONE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
          if (tcnt_d == TMO_C) begin
            state_d = ISSUE;
          end
        end
      end
      WAIT_DONE: begin
        if (!TXSch_TX_Busy) begin
          bytes_d = bytes_q - 2'd1;
          if (bytes_q == 2'd1) begin
            state_d = IDLE;
          end else begin
            txbuf_d = {8'h00, txbuf_q[15:8]};
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A grant frees the slot on the same edge, so a coincident pulse is kept.
    rf_pend_d  = rf_pend_q & ~grant_rf;
    alu_pend_d = alu_pend_q & ~grant_alu;

    if (TXSch_RF_RdValid) begin
      if (rf_pend_d) begin
        ovr_rf = 1'b1;
      end else begin
        rf_data_d = TXSch_RF_RdData;
        rf_pend_d = 1'b1;
      end
    end

    if (TXSch_ALU_Valid) begin
      if (alu_pend_d) begin
        ovr_alu = 1'b1;
      end else begin
        alu_data_d = TXSch_ALU_Out;
        alu_pend_d = 1'b1;
      end
    end

    ovr_d = ovr_rf | ovr_alu;
  end

  always_ff @(posedge TXSch_CLK) begin
    if (TXSch_RST) begin
      state_q      <= IDLE;
      rf_data_q    <= 8'h00;
      rf_pend_q    <= 1'b0;
      alu_data_q   <= 16'h0000;
      alu_pend_q   <= 1'b0;
      last_grant_q <= 1'b1;
      txbuf_q      <= 16'h0000;
      bytes_q      <= 2'd0;
      tcnt_q       <= 8'd0;
      pdata_q      <= 8'h00;
      dv_q         <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rf_data_q    <= rf_data_d;
      rf_pend_q    <= rf_pend_d;
      alu_data_q   <= alu_data_d;
      alu_pend_q   <= alu_pend_d;
      last_grant_q <= last_grant_d;
      txbuf_q      <= txbuf_d;
      bytes_q      <= bytes_d;
      tcnt_q       <= tcnt_d;
      pdata_q      <= pdata_d;
      dv_q         <= dv_d;
      ovr_q        <= ovr_d;
    end
  end

  assign TXSch_TX_Pdata      = pdata_q;
  assign TXSch_TX_Data_Valid = dv_q;
  assign TXSch_Overrun       = ovr_q;
  assign TXSch_Busy          = rf_pend_q | alu_pend_q | (state_q != IDLE);

endmodule
`default_nettype wire
